// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing unit: PC, sticky condition register,
// conditional relative branches, halt detection and a retired-instruction counter.
module fetch_unit #(
    parameter int PC_W = 8,
    parameter int IW   = 9
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic [IW-1:0]   InstrData,
    input  logic            Branch,
    input  logic            FlagWrite,
    input  logic [2:0]      Flag,
    input  logic            Eq,
    input  logic            Lt,
    output logic [PC_W-1:0] InstrAddr,
    output logic [IW-1:0]   Instr,
    output logic            InstrValid,
    output logic            Done,
    output logic [15:0]     RetireCount,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [2:0]      cond;
    logic            halt_word;
    logic            taken;
    logic            jump;
    logic [PC_W-1:0] offset;

    assign Instr     = InstrData;
    assign InstrAddr = pc;
    assign dbg_state = state;
    assign halt_word = &InstrData;
    assign offset    = {{(PC_W-6){InstrData[5]}}, InstrData[5:0]};

    always_comb begin
        taken = 1'b0;
        case (cond)
            3'b000:  taken = ~Eq;
            3'b001:  taken = Eq;
            3'b010:  taken = Lt;
            3'b011:  taken = Lt | Eq;
            3'b100:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // A branch that also writes the flags is a "set branch flag" op, never a jump.
    assign jump = Branch & ~FlagWrite & taken;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            pc          <= '0;
            cond        <= 3'b100;
            RetireCount <= 16'd0;
            InstrValid  <= 1'b0;
            Done        <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (Start) begin
                        state       <= RUN;
                        pc          <= '0;
                        cond        <= 3'b100;
                        RetireCount <= 16'd0;
                        InstrValid  <= 1'b1;
                        Done        <= 1'b0;
                    end
                end
                RUN: begin
                    if (FlagWrite) cond <= Flag;
                    if (RetireCount != 16'hFFFF) RetireCount <= RetireCount + 16'd1;
                    // PC stays on the halt word so it remains visible while Done is high.
                    if (halt_word) begin
                        state      <= HALT;
                        InstrValid <= 1'b0;
                        Done       <= 1'b1;
                    end else if (jump) begin
                        pc <= pc + offset;
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    InstrValid <= 1'b0;
                    Done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table-driven instruction memory and decoder outputs,
// checked against a behavioural model of the program-sequencing rules.
module tb_fetch_unit;

    logic       Clk;
    logic       Reset_n;
    logic       Start;
    logic [8:0] InstrData;
    logic       Branch;
    logic       FlagWrite;
    logic [2:0] Flag;
    logic       Eq;
    logic       Lt;
    logic [7:0] InstrAddr;
    logic [8:0] Instr;
    logic       InstrValid;
    logic       Done;
    logic [15:0] RetireCount;
    logic [1:0] dbg_state;

    logic [8:0] mem    [256];
    logic       br_t   [256];
    logic       fw_t   [256];
    logic [2:0] flag_t [256];
    logic       eq_t   [256];
    logic       lt_t   [256];

    int checks = 0;
    int errors = 0;

    // model: m_st 0 = idle, 1 = running, 2 = halted
    int m_st, m_pc, m_cond, m_cnt;

    fetch_unit #(.PC_W(8), .IW(9)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .InstrData(InstrData),
        .Branch(Branch), .FlagWrite(FlagWrite), .Flag(Flag), .Eq(Eq), .Lt(Lt),
        .InstrAddr(InstrAddr), .Instr(Instr), .InstrValid(InstrValid), .Done(Done),
        .RetireCount(RetireCount), .dbg_state(dbg_state)
    );

    assign InstrData = mem[InstrAddr];
    assign Branch    = br_t[InstrAddr];
    assign FlagWrite = fw_t[InstrAddr];
    assign Flag      = flag_t[InstrAddr];
    assign Eq        = eq_t[InstrAddr];
    assign Lt        = lt_t[InstrAddr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic bit rule_taken(int c, bit e, bit l);
        if (c == 0) return !e;
        if (c == 1) return e;
        if (c == 2) return l;
        if (c == 3) return l || e;
        if (c == 4) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_prog();
        for (int a = 0; a < 256; a++) begin
            mem[a] = 9'h000; br_t[a] = 0; fw_t[a] = 0; flag_t[a] = 0; eq_t[a] = 0; lt_t[a] = 0;
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pc = 0; m_cond = 4; m_cnt = 0;
    endtask

    // advance the model by one clock using the current inputs, then clock the DUT
    task automatic step();
        int off;
        bit jmp;
        if (m_st != 1) begin
            if (Start) begin m_st = 1; m_pc = 0; m_cnt = 0; m_cond = 4; end
        end else begin
            jmp = br_t[m_pc] && !fw_t[m_pc] && rule_taken(m_cond, eq_t[m_pc], lt_t[m_pc]);
            off = int'(mem[m_pc][5:0]);
            if (off >= 32) off = off - 64;
            if (fw_t[m_pc]) m_cond = int'(flag_t[m_pc]);
            m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (mem[m_pc] == 9'h1FF) m_st = 2;
            else if (jmp) m_pc = (m_pc + off + 256) % 256;
            else m_pc = (m_pc + 1) % 256;
        end
        @(posedge Clk); #1;
    endtask

    task automatic do_reset();
        #2 Reset_n = 1'b0;
        model_reset();
        @(posedge Clk); #1;
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (InstrAddr !== 8'h00 || InstrValid !== 1'b0 || Done !== 1'b0 || RetireCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_init addr=%h valid=%b done=%b cnt=%0d want 00/0/0/0",
                     InstrAddr, InstrValid, Done, RetireCount);
        end
        Reset_n = 1'b1;
        clear_prog();
        Start = 1'b1; step(); Start = 1'b0;
        for (int i = 0; i < 23; i++) step();
        checks++;
        if (InstrAddr !== 8'h17 || InstrValid !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun addr=%h valid=%b want 17/1", InstrAddr, InstrValid);
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (InstrAddr !== 8'h00 || InstrValid !== 1'b0 || Done !== 1'b0 || RetireCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_async addr=%h valid=%b done=%b cnt=%0d want 00/0/0/0",
                     InstrAddr, InstrValid, Done, RetireCount);
        end
        model_reset();
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (InstrAddr !== 8'h00 || InstrValid !== 1'b0 || RetireCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_noprogress addr=%h valid=%b cnt=%0d want 00/0/0",
                     InstrAddr, InstrValid, RetireCount);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        clear_prog();
        for (int a = 0; a < 5; a++) mem[a] = 9'($urandom_range(0, 9'h1FE));
        mem[5] = 9'h1FF;
        Start = 1'b1; step(); Start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (InstrAddr !== 8'(i) || InstrValid !== 1'b1 || Done !== 1'b0 || Instr !== mem[i]) begin
                errors++;
                $display("FAIL seq_fetch addr=%h valid=%b done=%b instr=%h want %h/1/0/%h",
                         InstrAddr, InstrValid, Done, Instr, 8'(i), mem[i]);
            end
            step();
        end
        checks++;
        if (Done !== 1'b1 || InstrValid !== 1'b0 || RetireCount !== 16'd6 || InstrAddr !== 8'h05) begin
            errors++;
            $display("FAIL seq_halt done=%b valid=%b cnt=%0d addr=%h want 1/0/6/05",
                     Done, InstrValid, RetireCount, InstrAddr);
        end
        step();
        checks++;
        if (Done !== 1'b1 || RetireCount !== 16'd6 || InstrAddr !== 8'h05) begin
            errors++;
            $display("FAIL seq_hold done=%b cnt=%0d addr=%h want 1/6/05", Done, RetireCount, InstrAddr);
        end
    endtask

    task automatic test_cond_jump();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            clear_prog();
            mem[3] = 9'h041; br_t[3] = 1; fw_t[3] = 1; flag_t[3] = 3'b001;
            mem[4] = 9'h03C; br_t[4] = 1; eq_t[4] = (k == 0);
            mem[5] = 9'h1FF;
            Start = 1'b1; step(); Start = 1'b0;
            for (int i = 0; i < 4; i++) step();
            checks++;
            if (InstrAddr !== 8'h04) begin
                errors++;
                $display("FAIL cj_setflag addr=%h want 04", InstrAddr);
            end
            step();
            checks++;
            if (InstrAddr !== ((k == 0) ? 8'h00 : 8'h05) || InstrValid !== 1'b1) begin
                errors++;
                $display("FAIL cj_target eq=%0d addr=%h valid=%b want %h/1",
                         (k == 0), InstrAddr, InstrValid, (k == 0) ? 8'h00 : 8'h05);
            end
        end
    endtask

    task automatic test_le_unused();
        do_reset();
        clear_prog();
        mem[0] = 9'h0C0; br_t[0] = 1; fw_t[0] = 1; flag_t[0] = 3'b011;
        mem[1] = 9'h003; br_t[1] = 1; eq_t[1] = 1; lt_t[1] = 0;
        mem[4] = 9'h0C0; br_t[4] = 1; fw_t[4] = 1; flag_t[4] = 3'b110;
        mem[5] = 9'h002; br_t[5] = 1; eq_t[5] = 1; lt_t[5] = 1;
        mem[6] = 9'h1FF;
        Start = 1'b1; step(); Start = 1'b0;
        step(); step();
        checks++;
        if (InstrAddr !== 8'h04) begin
            errors++;
            $display("FAIL le_taken addr=%h want 04", InstrAddr);
        end
        step(); step();
        checks++;
        if (InstrAddr !== 8'h06) begin
            errors++;
            $display("FAIL unused_nottaken addr=%h want 06", InstrAddr);
        end
        step();
        checks++;
        if (Done !== 1'b1 || RetireCount !== 16'd5) begin
            errors++;
            $display("FAIL le_halt done=%b cnt=%0d want 1/5", Done, RetireCount);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        clear_prog();
        mem[2] = 9'h03C; br_t[2] = 1;
        Start = 1'b1; step(); Start = 1'b0;
        step(); step(); step();
        checks++;
        if (InstrAddr !== 8'hFE) begin
            errors++;
            $display("FAIL wrap_backjump addr=%h want fe", InstrAddr);
        end
        step();
        checks++;
        if (InstrAddr !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_ff addr=%h want ff", InstrAddr);
        end
        step();
        checks++;
        if (InstrAddr !== 8'h00 || RetireCount !== 16'd5) begin
            errors++;
            $display("FAIL wrap_zero addr=%h cnt=%0d want 00/5", InstrAddr, RetireCount);
        end
    endtask

    task automatic test_restart();
        do_reset();
        clear_prog();
        mem[0] = 9'h002; br_t[0] = 1;
        mem[2] = 9'h080; fw_t[2] = 1; flag_t[2] = 3'b110;
        mem[3] = 9'h1FF;
        Start = 1'b1; step(); Start = 1'b0;
        step(); step(); step();
        checks++;
        if (Done !== 1'b1 || InstrAddr !== 8'h03 || RetireCount !== 16'd3) begin
            errors++;
            $display("FAIL rs_halt done=%b addr=%h cnt=%0d want 1/03/3", Done, InstrAddr, RetireCount);
        end
        Start = 1'b1; step();
        checks++;
        if (InstrAddr !== 8'h00 || RetireCount !== 16'd0 || InstrValid !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL rs_restart addr=%h cnt=%0d valid=%b done=%b want 00/0/1/0",
                     InstrAddr, RetireCount, InstrValid, Done);
        end
        step();
        checks++;
        if (InstrAddr !== 8'h02 || RetireCount !== 16'd1) begin
            errors++;
            $display("FAIL rs_cond_start_in_run addr=%h cnt=%0d want 02/1", InstrAddr, RetireCount);
        end
        step(); Start = 1'b0; step();
        checks++;
        if (Done !== 1'b1 || RetireCount !== 16'd3) begin
            errors++;
            $display("FAIL rs_rehalt done=%b cnt=%0d want 1/3", Done, RetireCount);
        end
    endtask

    task automatic test_random();
        do_reset();
        clear_prog();
        for (int a = 0; a < 256; a++) begin
            if ($urandom_range(0, 19) == 0) begin
                mem[a] = 9'h1FF;
            end else begin
                mem[a]    = 9'($urandom_range(0, 9'h1FE));
                br_t[a]   = ($urandom_range(0, 2) == 0);
                fw_t[a]   = ($urandom_range(0, 3) == 0);
                flag_t[a] = 3'($urandom_range(0, 7));
                eq_t[a]   = 1'($urandom_range(0, 1));
                lt_t[a]   = 1'($urandom_range(0, 1));
            end
        end
        for (int i = 0; i < 400; i++) begin
            Start = ($urandom_range(0, 7) == 0);
            step();
            checks++;
            if (InstrAddr !== 8'(m_pc) || InstrValid !== (m_st == 1) || Done !== (m_st == 2) ||
                RetireCount !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL rand_cycle%0d addr=%h valid=%b done=%b cnt=%0d want %h/%b/%b/%0d",
                         i, InstrAddr, InstrValid, Done, RetireCount,
                         8'(m_pc), (m_st == 1), (m_st == 2), m_cnt);
            end
        end
        Start = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0;
        Start   = 1'b0;
        clear_prog();
        model_reset();
        #12;
        test_reset();
        test_sequential();
        test_cond_jump();
        test_le_unused();
        test_wrap();
        test_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, program counter width (instruction memory depth 2**PC_W).
REQ-002 SHALL have parameter IW, default 9, instruction width.
REQ-003 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  level/pulse request to begin program at address 0.
REQ-006 SHALL have port InstrData  input  IW  word returned combinationally by instruction memory for InstrAddr.
REQ-007 SHALL have port Branch  input  1  branch request from the control decoder.
REQ-008 SHALL have port FlagWrite  input  1  condition-register write request from the control decoder.
REQ-009 SHALL have port Flag  input  3  condition code from the control decoder.
REQ-010 SHALL have port Eq  input  1  ALU compare result "equal", valid in the branch cycle.
REQ-011 SHALL have port Lt  input  1  ALU compare result "less than", valid in the branch cycle.
REQ-012 SHALL have port InstrAddr  output  PC_W  current PC, drives instruction memory.
REQ-013 SHALL have port Instr  output  IW  instruction to the control decoder, equal to InstrData.
REQ-014 SHALL have port InstrValid  output  1  high only in RUN; datapath gates all writes with it.
REQ-015 SHALL have port Done  output  1  high while in HALT.
REQ-016 SHALL have port RetireCount  output  16  number of instructions retired since last Start.

Function
REQ-017 SHALL implement states IDLE, RUN, HALT; IDLE->RUN on Start; RUN->HALT when Instr == all ones (halt opcode); HALT->RUN on Start; Start ignored in RUN.
REQ-018 SHALL, on entering RUN from IDLE or HALT, load PC=0, RetireCount=0 and Cond=3'b100.
REQ-019 SHALL hold PC, Cond and RetireCount unchanged in IDLE and HALT.
REQ-020 SHALL hold a 3-bit condition register Cond, written with Flag in a RUN cycle where FlagWrite=1.
REQ-021 SHALL treat Branch=1 with FlagWrite=1 as a condition write only (no jump); PC advances by 1.
REQ-022 SHALL evaluate a jump in a RUN cycle with Branch=1, FlagWrite=0: taken = (Cond 000: !Eq; 001: Eq; 010: Lt; 011: Lt|Eq; 100: 1; 101-111: 0).
REQ-023 SHALL on taken jump load PC = PC + sign-extended Instr[5:0], modulo 2**PC_W; target computed from pre-update PC.
REQ-024 SHALL on any other RUN cycle (not halt) load PC = PC + 1, wrapping 2**PC_W-1 -> 0.
REQ-025 SHALL keep PC unchanged on the halt cycle so InstrAddr points at the halt word while Done=1.
REQ-026 SHALL increment RetireCount once per RUN cycle including the halt cycle, saturating at 16'hFFFF.
REQ-027 SHALL retain Cond across a taken or not-taken jump (condition is sticky until the next write).
REQ-028 SHALL have zero-cycle fetch latency: Instr reflects InstrData for the current InstrAddr in the same cycle.

Reset
REQ-029 SHALL, while Reset_n=0, force state IDLE, PC=0, Cond=3'b100, RetireCount=0, InstrValid=0, Done=0, independent of Clk.
REQ-030 SHALL, on reset assertion mid-RUN, abandon the current instruction with no PC/Cond/count update and require a new Start after release.

Verification
REQ-031 SHALL verify reset: Reset_n=0 mid-RUN at PC=0x17 -> InstrAddr=0, InstrValid=0, Done=0 immediately; no progress until Start.
REQ-032 SHALL verify sequential fetch: Start, 5 non-branch words then 0x1FF at addr 5 -> InstrAddr 0..5, Done=1 next cycle, RetireCount=6, InstrAddr holds 5.
REQ-033 SHALL verify conditional jump: sbf eq (Flag=001, Branch=1, FlagWrite=1) at PC=3, then b offset 6'b111100 at PC=4 with Eq=1 -> next PC=0; with Eq=0 -> next PC=5.
REQ-034 SHALL verify le and unused codes: Cond=011, Lt=0 Eq=1 -> taken; Cond=110 -> never taken regardless of Eq/Lt.
REQ-035 SHALL verify wrap: PC=0xFF non-branch -> PC=0x00; PC=0x02 taken jump offset -4 -> PC=0xFE.
REQ-036 SHALL verify restart: in HALT assert Start -> PC=0, RetireCount=0, Cond=100, InstrValid=1 next cycle; Start during RUN has no effect.
